// File: rtl/prog_loader_pkg.sv
// ----------------------------------------------------------------------------
// prog_loader_pkg
// Shared types and constants for the boot-time program loader.
//   state_e        : loader FSM states
//   BYTES_PER_WORD : stream bytes per 32-bit word
//   idx_width()    : word-index width able to hold a given word-count limit
// ----------------------------------------------------------------------------
package prog_loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StClr,
        StHdr,
        StData,
        StWrite,
        StCsum,
        StRun,
        StErr
    } state_e;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned MAX_WORDS_DFLT = 1024;

    function automatic int unsigned idx_width(input int unsigned max_words);
        return $clog2(max_words + 1);
    endfunction

    localparam int unsigned IDX_W = idx_width(MAX_WORDS_DFLT);

endpackage

// File: rtl/prog_loader_byte_packer.sv
// ----------------------------------------------------------------------------
// prog_loader_byte_packer
// Assembles accepted stream bytes into little-endian 32-bit words (first byte
// lands in bits [7:0]). o_word_valid pulses combinationally alongside the
// fourth byte, with o_word already holding the completed word.
// Ports:
//   i_clk, i_rst_n  : clock, async active-low reset
//   i_clr           : synchronous clear of the partial word and byte count
//   i_byte_valid    : a byte is accepted this cycle
//   i_byte          : accepted byte
//   o_word          : completed word (valid together with o_word_valid)
//   o_word_valid    : fourth byte of a word accepted this cycle
// ----------------------------------------------------------------------------
module prog_loader_byte_packer
    import prog_loader_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clr,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_valid
);

    logic [1:0]  r_cnt;
    // Only the three earlier bytes need storing; the last arrives on i_byte.
    logic [23:0] r_word;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= 2'd0;
            r_word <= 24'd0;
        end else if (i_clr) begin
            r_cnt  <= 2'd0;
            r_word <= 24'd0;
        end else if (i_byte_valid) begin
            r_cnt  <= r_cnt + 2'd1;
            r_word <= {i_byte, r_word[23:8]};
        end
    end

    assign o_word       = {i_byte, r_word};
    assign o_word_valid = i_byte_valid && (r_cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/prog_loader.sv
// ----------------------------------------------------------------------------
// prog_loader
// Boot-time loader in front of the core's program-load port. Receives a
// framed byte stream (4-byte LE word count N, N LE words, 1 XOR checksum
// byte), writes each word through the rom_* port while holding the core in
// register reset, and releases the core only on a good checksum.
// Ports:
//   i_clk, i_rst_n       : clock, async active-low reset
//   i_load_req           : start a load (honoured in IDLE/RUN/ERR)
//   i_in_valid/i_in_data : byte stream, transfers when i_in_valid && o_in_ready
//   o_in_ready           : loader accepts a byte this cycle
//   i_ebreak             : core ebreak indication
//   o_rom_wen/addr/wdata : word write strobe, byte address, data
//   o_core_reg_reset     : core register/PC reset (low only while running)
//   o_core_mem_reset     : core memory clear (one cycle per load)
//   o_done, o_err        : load complete / load failed (sticky to next load)
//   o_halted             : ebreak seen while running (sticky to next load)
// All outputs are registered.
// ----------------------------------------------------------------------------
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = MAX_WORDS_DFLT
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_load_req,
    input  logic        i_in_valid,
    input  logic [7:0]  i_in_data,
    output logic        o_in_ready,
    input  logic        i_ebreak,
    output logic        o_rom_wen,
    output logic [31:0] o_rom_addr,
    output logic [31:0] o_rom_wdata,
    output logic        o_core_reg_reset,
    output logic        o_core_mem_reset,
    output logic        o_done,
    output logic        o_err,
    output logic        o_halted
);

    localparam int unsigned IdxW = idx_width(MAX_WORDS);

    state_e            r_state;
    state_e            w_state_d;
    logic [IdxW-1:0]   r_idx;
    logic [IdxW-1:0]   w_idx_inc;
    logic [IdxW-1:0]   r_n;
    logic [7:0]        r_csum;

    logic              r_in_ready;
    logic              r_rom_wen;
    logic [31:0]       r_rom_addr;
    logic [31:0]       r_rom_wdata;
    logic              r_core_reg_reset;
    logic              r_core_mem_reset;
    logic              r_done;
    logic              r_err;
    logic              r_halted;

    logic              w_fire;
    logic              w_pack_valid;
    logic              w_clr;
    logic [31:0]       w_word;
    logic              w_word_valid;
    logic              w_hdr_bad;

    assign w_fire       = i_in_valid && r_in_ready;
    // Header and data bytes both feed the packer and the running checksum.
    assign w_pack_valid = w_fire && ((r_state == StHdr) || (r_state == StData));
    assign w_clr        = (r_state == StClr);
    assign w_idx_inc    = r_idx + 1'b1;
    assign w_hdr_bad    = (w_word == 32'd0) || (w_word > 32'(MAX_WORDS));

    prog_loader_byte_packer u_packer (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_clr        (w_clr),
        .i_byte_valid (w_pack_valid),
        .i_byte       (i_in_data),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (i_load_req) w_state_d = StClr;
            StClr:   w_state_d = StHdr;
            StHdr:   if (w_word_valid) w_state_d = w_hdr_bad ? StErr : StData;
            StData:  if (w_word_valid) w_state_d = StWrite;
            StWrite: w_state_d = (w_idx_inc == r_n) ? StCsum : StData;
            StCsum:  if (w_fire) w_state_d = (i_in_data == r_csum) ? StRun : StErr;
            StRun:   if (i_load_req) w_state_d = StClr;
            StErr:   if (i_load_req) w_state_d = StClr;
            default: w_state_d = StIdle;
        endcase
    end

    // Datapath: index, word count, checksum.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_idx   <= '0;
            r_n     <= '0;
            r_csum  <= 8'd0;
        end else begin
            r_state <= w_state_d;
            if (w_clr) begin
                r_idx  <= '0;
                r_n    <= '0;
                r_csum <= 8'd0;
            end else begin
                if (r_state == StWrite) r_idx <= w_idx_inc;
                if (w_pack_valid) r_csum <= r_csum ^ i_in_data;
                // N is only kept when in range, so it fits the index width.
                if ((r_state == StHdr) && w_word_valid && !w_hdr_bad) begin
                    r_n <= w_word[IdxW-1:0];
                end
            end
        end
    end

    // Outputs decoded from the next state so they line up with r_state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_in_ready       <= 1'b0;
            r_rom_wen        <= 1'b0;
            r_rom_addr       <= 32'd0;
            r_rom_wdata      <= 32'd0;
            r_core_reg_reset <= 1'b1;
            r_core_mem_reset <= 1'b0;
            r_done           <= 1'b0;
            r_err            <= 1'b0;
            r_halted         <= 1'b0;
        end else begin
            r_in_ready       <= (w_state_d == StHdr) || (w_state_d == StData) ||
                                (w_state_d == StCsum);
            r_rom_wen        <= (w_state_d == StWrite);
            if (w_state_d == StWrite) begin
                r_rom_addr  <= BASE_ADDR + (32'(r_idx) << 2);
                r_rom_wdata <= w_word;
            end
            r_core_reg_reset <= (w_state_d != StRun);
            r_core_mem_reset <= (w_state_d == StClr);
            r_done           <= (w_state_d == StRun);
            r_err            <= (w_state_d == StErr);
            if (w_state_d == StClr) begin
                r_halted <= 1'b0;
            end else if ((r_state == StRun) && i_ebreak) begin
                r_halted <= 1'b1;
            end
        end
    end

    assign o_in_ready       = r_in_ready;
    assign o_rom_wen        = r_rom_wen;
    assign o_rom_addr       = r_rom_addr;
    assign o_rom_wdata      = r_rom_wdata;
    assign o_core_reg_reset = r_core_reg_reset;
    assign o_core_mem_reset = r_core_mem_reset;
    assign o_done           = r_done;
    assign o_err            = r_err;
    assign o_halted         = r_halted;

endmodule

// File: tb/tb_prog_loader.sv
// ----------------------------------------------------------------------------
// tb_prog_loader
// Directed stimulus for prog_loader. Expected rom writes are queued as words
// are sent; a monitor pops and compares on every rom_wen strobe.
// ----------------------------------------------------------------------------
module tb_prog_loader;
    import prog_loader_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int unsigned MAXW = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_req;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        ebreak;
    logic        rom_wen;
    logic [31:0] rom_addr;
    logic [31:0] rom_wdata;
    logic        core_reg_reset;
    logic        core_mem_reset;
    logic        done;
    logic        err;
    logic        halted;

    int          total = 0;
    int          bad   = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_e;

    always #5 clk = ~clk;

    prog_loader #(
        .BASE_ADDR (BASE),
        .MAX_WORDS (MAXW)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_load_req       (load_req),
        .i_in_valid       (in_valid),
        .i_in_data        (in_data),
        .o_in_ready       (in_ready),
        .i_ebreak         (ebreak),
        .o_rom_wen        (rom_wen),
        .o_rom_addr       (rom_addr),
        .o_rom_wdata      (rom_wdata),
        .o_core_reg_reset (core_reg_reset),
        .o_core_mem_reset (core_mem_reset),
        .o_done           (done),
        .o_err            (err),
        .o_halted         (halted)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %08h want %08h", name, act, want);
        end
    endtask

    // Scoreboard monitor: every write strobe must match the queued expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && rom_wen === 1'b1) begin
            check("wr_in_ready_low", {31'd0, in_ready}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", rom_addr, mon_e[63:32]);
                check("wr_data", rom_wdata, mon_e[31:0]);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("byte_accept_timeout", 32'd1, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
    endtask

    task automatic send_data(input logic [31:0] w, input logic [31:0] addr, input int gap);
        exp_q.push_back({addr, w});
        send_word(w, gap);
    endtask

    // Pulse load_req; the following cycle is CLR.
    task automatic do_load();
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        check("clr_mem_reset", {31'd0, core_mem_reset}, 32'd1);
        check("clr_reg_reset", {31'd0, core_reg_reset}, 32'd1);
        check("clr_err",       {31'd0, err},            32'd0);
        check("clr_halted",    {31'd0, halted},         32'd0);
        @(negedge clk);
        check("hdr_mem_reset", {31'd0, core_mem_reset}, 32'd0);
    endtask

    // Two-word program; checksum of all header+data bytes is 0x67.
    task automatic frame(input int gap, input logic [7:0] flip);
        send_word(32'd2, gap);
        send_data(32'h0010_0513, BASE + 32'd0, gap);
        send_data(32'h0010_0073, BASE + 32'd4, gap);
        send_byte(8'h67 ^ flip, gap);
    endtask

    task automatic wait_end();
        int n;
        n = 0;
        while (done !== 1'b1 && err !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("end_timeout", 32'd1, 32'd0);
    endtask

    task automatic check_status(input string tag, input logic d, input logic e, input logic rr);
        check({tag, "_done"},      {31'd0, done},           {31'd0, d});
        check({tag, "_err"},       {31'd0, err},            {31'd0, e});
        check({tag, "_reg_reset"}, {31'd0, core_reg_reset}, {31'd0, rr});
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"},  {31'd0, in_ready},       32'd0);
        check({tag, "_wen"},       {31'd0, rom_wen},        32'd0);
        check({tag, "_addr"},      rom_addr,                32'd0);
        check({tag, "_wdata"},     rom_wdata,               32'd0);
        check({tag, "_reg_reset"}, {31'd0, core_reg_reset}, 32'd1);
        check({tag, "_mem_reset"}, {31'd0, core_mem_reset}, 32'd0);
        check({tag, "_done"},      {31'd0, done},           32'd0);
        check({tag, "_err"},       {31'd0, err},            32'd0);
        check({tag, "_halted"},    {31'd0, halted},         32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        load_req = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        ebreak   = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_reg_reset", {31'd0, core_reg_reset}, 32'd1);

        // Happy path.
        do_load();
        frame(0, 8'h00);
        wait_end();
        check_status("happy", 1'b1, 1'b0, 1'b0);

        // Halt is sticky while running.
        ebreak = 1'b1;
        @(negedge clk);
        ebreak = 1'b0;
        check("halt_set", {31'd0, halted}, 32'd1);
        repeat (3) @(negedge clk);
        check("halt_sticky", {31'd0, halted}, 32'd1);

        // Backpressure: three idle cycles before every byte.
        do_load();
        frame(3, 8'h00);
        wait_end();
        check_status("bp", 1'b1, 1'b0, 1'b0);

        // Bad checksum: writes still occur, then error.
        do_load();
        frame(0, 8'h01);
        wait_end();
        check_status("badcs", 1'b0, 1'b1, 1'b1);
        ebreak = 1'b1;
        @(negedge clk);
        ebreak = 1'b0;
        check("err_ebreak_ignored", {31'd0, halted}, 32'd0);

        // Bad headers: N=0 and N=MAX_WORDS+1, error right after 4th byte.
        do_load();
        send_word(32'd0, 0);
        check("hdr0_err", {31'd0, err}, 32'd1);
        check("hdr0_in_ready", {31'd0, in_ready}, 32'd0);
        do_load();
        send_word(MAXW + 1, 0);
        check("hdrmax_err", {31'd0, err}, 32'd1);

        // Reset mid-load, two bytes into the first word.
        do_load();
        send_word(32'd2, 0);
        send_byte(8'h13, 0);
        send_byte(8'h05, 0);
        in_valid = 1'b1;
        in_data  = 8'h10;
        check("pre_rst_in_ready", {31'd0, in_ready}, 32'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("async_rst");
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_load();
        frame(0, 8'h00);
        wait_end();
        check_status("reload", 1'b1, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
Boot-time program loader that sits directly upstream of the miniRV core's program-load port. It receives a framed byte stream (header, words, checksum) over a valid/ready interface and assembles little-endian 32-bit words. Each word is written through the core's rom_wen/rom_addr/rom_wdata port while the core is held in register reset. On a good checksum it releases the core to run; on any framing or checksum error it keeps the core held.

Parameters:
BASE_ADDR, 32'h0000_0000, byte address of the first loaded word
MAX_WORDS, 1024, largest accepted word count N

Ports:
clk  in  1  single clock, all state updates on rising edge
reset  in  1  asynchronous, active-low; loader state cleared while 0
load_req  in  1  one-cycle pulse that starts a load; accepted only in IDLE, RUN or ERR
in_valid  in  1  byte available on in_data
in_data  in  8  stream byte
in_ready  out  1  loader accepts a byte this cycle; a byte transfers when in_valid&&in_ready
ebreak  in  1  core ebreak indication
rom_wen  out  1  write strobe to core load port
rom_addr  out  32  write byte address
rom_wdata  out  32  write data
core_reg_reset  out  1  active-high register/PC reset to core
core_mem_reset  out  1  active-high memory clear to core
done  out  1  load completed, core running
err  out  1  sticky load error until next load_req
halted  out  1  sticky: ebreak seen while in RUN

Behaviour:
- Reset (reset=0, async): state=IDLE; rom_wen=0, rom_addr=0, rom_wdata=0, core_reg_reset=1, core_mem_reset=0, in_ready=0, done=0, err=0, halted=0. All outputs are registered.
- IDLE: core_reg_reset=1. load_req -> CLR.
- CLR: exactly one cycle. core_mem_reset=1, core_reg_reset=1; clears word index, byte count, checksum, err, halted and done. Next state is HDR.
- HDR: in_ready=1. Collects 4 bytes into N, little-endian (first byte = N[7:0]). After the 4th byte:
  - N==0 or N>MAX_WORDS -> ERR.
  - Otherwise -> DATA.
- DATA: in_ready=1. Collects 4 bytes little-endian into a word. The 4th accepted byte -> WRITE.
- WRITE: exactly one cycle; in_ready=0.
  - Drives rom_wen=1, rom_addr=BASE_ADDR+4*idx (32-bit, wraps modulo 2^32), rom_wdata=word.
  - idx increments. If idx (post-increment) == N -> CSUM, else -> DATA.
  - rom_wen is high only in WRITE, so there is exactly one strobe per word.
- CSUM: in_ready=1. Accepts 1 byte.
  - If it equals the XOR of all header and data bytes -> RUN, else -> ERR.
- RUN: core_reg_reset=0, done=1, in_ready=0. ebreak=1 sets halted (sticky). load_req -> CLR.
- ERR: err=1, core_reg_reset=1, in_ready=0. load_req -> CLR.
- Gaps in in_valid stall the current state indefinitely, with no timeout. Bytes presented while in_ready=0 are not consumed.
- load_req outside IDLE/RUN/ERR is ignored.
- ebreak is ignored outside RUN.
- Reset asserted mid-load aborts immediately to IDLE. The partial word is discarded and core memory keeps whatever was already written.
- The byte counter is 2 bits wide; idx is wide enough to hold MAX_WORDS.
- Checksum is an 8-bit running XOR, updated on every accepted byte except the checksum byte itself.

Decomposition:
- Package prog_loader_pkg:
  - state enum {IDLE, CLR, HDR, DATA, WRITE, CSUM, RUN, ERR}.
  - Constant BYTES_PER_WORD=4.
  - Localparam for idx width, $clog2(MAX_WORDS+1).
- One sub-module, byte_packer:
  - Shifts accepted bytes into a 32-bit little-endian word.
  - Pulses word_valid on the 4th byte.
  - Is cleared by a clr input; used for both header and data words.

Test Plan:
- Happy path: reset release, load_req, stream 02 00 00 00 | 13 05 10 00 | 73 00 10 00 | checksum.
  - Expect core_mem_reset for one cycle.
  - Expect rom_wen twice: addr 0x0 / data 0x00100513, then addr 0x4 / data 0x00100073.
  - Then done=1, core_reg_reset=0, err=0.
- Backpressure: same stream with in_valid low for 3 cycles between every byte.
  - Expect identical rom_* writes and ordering.
  - in_ready low during WRITE cycles.
- Bad checksum: correct frame with the checksum byte XORed by 0x01.
  - Both writes still occur; then err=1, done=0, core_reg_reset=1.
  - A later load_req clears err.
- Bad header: N=0 (00 00 00 00), and separately N=MAX_WORDS+1.
  - Expect ERR right after the 4th header byte, no rom_wen.
- Reset mid-load: drop reset after 2 bytes of word 1.
  - All outputs return to reset values asynchronously (before the next clk edge).
  - A fresh load_req and full frame then load correctly from BASE_ADDR.
- Halt: in RUN, pulse ebreak for 1 cycle -> halted=1 and stays 1. The next load_req clears halted in CLR.
